// File: rtl/fifo_read_streamer_pkg.sv
// Shared constants, FSM state type and helpers for fifo_read_streamer.
package fifo_read_streamer_pkg;

    localparam int unsigned FRS_DATA_WIDTH = 8;
    localparam int unsigned FRS_SKID_DEPTH = 2;
    localparam int unsigned STAT_W         = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } frs_state_e;

    function automatic logic [STAT_W-1:0] frs_sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_read_streamer_if.sv
// FIFO read port plus downstream valid/ready stream; master is the streamer's view.
interface fifo_read_streamer_if #(
    parameter int unsigned DATA_WIDTH = fifo_read_streamer_pkg::FRS_DATA_WIDTH
);

    logic                  rd_enb;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  underflow;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output rd_enb,
        input  rd_data,
        input  empty,
        input  underflow,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  rd_enb,
        output rd_data,
        output empty,
        output underflow,
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface

// File: rtl/fifo_read_streamer_skid_buf.sv
// frs_skid_buf: two-entry in-order buffer with push/pop/clear, exposing count and head word.
module frs_skid_buf
    import fifo_read_streamer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FRS_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [1:0]            count_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr_i) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = ~tail_q;
            if (pop_i)  head_d = ~head_q;
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= '0;
        end else begin
            if (push_i && !clr_i) mem_q[tail_q] <= push_data_i;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_i && !clr_i && count_q == 2'd2));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop_i && count_q == 2'd0));

endmodule

// File: rtl/fifo_read_streamer.sv
// Drains a synchronous FIFO read port into a valid/ready stream via a 2-entry skid buffer.
// Optional handshake/stall counters when FIFO_READ_STREAMER_STATS_EN is defined.
module fifo_read_streamer
    import fifo_read_streamer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FRS_DATA_WIDTH,
    parameter int unsigned SKID_DEPTH = FRS_SKID_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    fifo_read_streamer_if.master        bus,
    input  logic                        flush,
    output logic                        err_underflow,
    output logic                        busy
`ifdef FIFO_READ_STREAMER_STATS_EN
    ,
    output logic [STAT_W-1:0]           stat_words,
    output logic [STAT_W-1:0]           stat_stalls
`endif
);

    if (SKID_DEPTH != 2) begin : g_bad_depth
        $error("fifo_read_streamer: SKID_DEPTH must be 2");
    end

    localparam logic [2:0] DEPTH_L = 3'(SKID_DEPTH);

    frs_state_e            state_q;
    logic                  inflight_q;
    logic                  err_q;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] head;
    logic                  m_valid_c;
    logic                  pop;
    logic                  push;
    logic                  rd_enb_c;
    logic [2:0]            occ_after_pop;

    // Credit check counts the word already in flight and frees the slot being popped this cycle.
    always_comb begin
        m_valid_c     = (count != 2'd0) && (state_q != FLUSH);
        pop           = m_valid_c && bus.m_ready;
        occ_after_pop = 3'(count) + 3'(inflight_q) - 3'(pop);
        rd_enb_c      = !rst && !bus.empty && !flush && (state_q != FLUSH)
                        && (occ_after_pop < DEPTH_L);
        push          = inflight_q && !flush && (state_q != FLUSH);
    end

    frs_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (flush),
        .push_i      (push),
        .push_data_i (bus.rd_data),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= rd_enb_c;
            if (bus.underflow) err_q <= 1'b1;
            if (flush) begin
                state_q <= FLUSH;
            end else begin
                unique case (state_q)
                    IDLE:    if (rd_enb_c) state_q <= ACTIVE;
                    ACTIVE:  if (count == 2'd0 && !inflight_q && !rd_enb_c) state_q <= IDLE;
                    FLUSH:   if (!inflight_q) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.rd_enb    = rd_enb_c;
    assign bus.m_valid   = m_valid_c;
    assign bus.m_data    = head;
    assign err_underflow = err_q;
    assign busy          = (count != 2'd0) || inflight_q;

`ifdef FIFO_READ_STREAMER_STATS_EN
    logic [STAT_W-1:0] words_q;
    logic [STAT_W-1:0] stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            words_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (pop)                      words_q  <= frs_sat_inc(words_q);
            if (m_valid_c && !bus.m_ready) stalls_q <= frs_sat_inc(stalls_q);
        end
    end

    assign stat_words  = words_q;
    assign stat_stalls = stalls_q;
`endif

    a_rd_not_empty: assert property (@(posedge clk) disable iff (rst)
        bus.rd_enb |-> !bus.empty);
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.m_valid && !bus.m_ready && !flush) |=> (bus.m_valid && $stable(bus.m_data)));

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Scoreboard bench for fifo_read_streamer: FIFO model + queue-level reference, directed and random phases.
// Stats counters are also checked when FIFO_READ_STREAMER_STATS_EN is defined.
module tb_fifo_read_streamer;

    localparam int unsigned DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   stamp;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    logic err_underflow;
    logic busy;
`ifdef FIFO_READ_STREAMER_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_stalls;
`endif

    int unsigned   n_tests;
    int unsigned   n_fail;
    int unsigned   cyc;
    exp_t          exp_q[$];
    logic [DW-1:0] fifo_q[$];
    int unsigned   rd_cycles[$];
    logic [DW-1:0] next_word;

    fifo_read_streamer_if #(.DATA_WIDTH(DW)) bus ();

    fifo_read_streamer #(
        .DATA_WIDTH (DW),
        .SKID_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .flush         (flush),
        .err_underflow (err_underflow),
        .busy          (busy)
`ifdef FIFO_READ_STREAMER_STATS_EN
        ,
        .stat_words    (stat_words),
        .stat_stalls   (stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // FIFO model: a read issued this cycle returns its word during the next cycle.
    task automatic step();
        logic          rd;
        logic [DW-1:0] w;
        @(negedge clk);
        rd = 1'b0;
        w  = '0;
        if (bus.rd_enb === 1'b1 && fifo_q.size() != 0) begin
            rd = 1'b1;
            w  = fifo_q.pop_front();
            if (rst !== 1'b1) begin
                exp_q.push_back('{data: w, stamp: cyc});
                rd_cycles.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.rd_data = rd ? w : DW'($urandom);
        bus.empty   = (fifo_q.size() == 0);
    endtask

    task automatic load(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            fifo_q.push_back(next_word);
            next_word++;
        end
        bus.empty = (fifo_q.size() == 0);
    endtask

    // Monitor: reference rules are word-level (read at t -> offered from t+2, at most 2 held/in flight).
    initial begin : monitor
        logic          hold_prev;
        logic [DW-1:0] data_prev;
        logic          flush_prev;
        logic          err_m;
        logic          hs;
        logic          exp_rd;
        logic          ready_word;
        int            occ;
        int unsigned   words_m;
        int unsigned   stalls_m;
        exp_t          e;
        hold_prev  = 1'b0;
        data_prev  = '0;
        flush_prev = 1'b0;
        err_m      = 1'b0;
        words_m    = 0;
        stalls_m   = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                exp_q.delete();
                err_m      = 1'b0;
                words_m    = 0;
                stalls_m   = 0;
                hold_prev  = 1'b0;
                flush_prev = 1'b0;
            end else begin
                occ = 0;
                foreach (exp_q[i]) if (exp_q[i].stamp < cyc) occ++;
                ready_word = (exp_q.size() != 0) && (exp_q[0].stamp + 2 <= cyc);
                hs         = bus.m_valid && bus.m_ready;
                exp_rd     = !bus.empty && !flush && !flush_prev && ((occ - (hs ? 1 : 0)) < 2);

                check("m_valid", 32'(bus.m_valid), 32'(ready_word));
                check("busy", 32'(busy), 32'(occ != 0));
                check("rd_enb", 32'(bus.rd_enb), 32'(exp_rd));
                check("err_underflow", 32'(err_underflow), 32'(err_m));
`ifdef FIFO_READ_STREAMER_STATS_EN
                check("stat_words", 32'(stat_words), words_m);
                check("stat_stalls", 32'(stat_stalls), stalls_m);
`endif
                if (hold_prev) begin
                    check("m_valid_held", 32'(bus.m_valid), 32'd1);
                    check("m_data_held", 32'(bus.m_data), 32'(data_prev));
                end
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL m_data_extra: got word 0x%0h, expected no word (cycle %0d)",
                                 bus.m_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", 32'(bus.m_data), 32'(e.data));
                    end
                end
                if (flush) exp_q.delete();
                if (bus.underflow) err_m = 1'b1;
                if (hs && words_m != 32'hFFFF) words_m++;
                if (bus.m_valid && !bus.m_ready && stalls_m != 32'hFFFF) stalls_m++;
                hold_prev  = bus.m_valid && !bus.m_ready && !flush;
                data_prev  = bus.m_data;
                flush_prev = flush;
            end
        end
    end

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at time 200000, expected to finish earlier");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int unsigned span;
        n_tests       = 0;
        n_fail        = 0;
        cyc           = 0;
        next_word     = 8'h01;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.m_ready   = 1'b0;
        bus.empty     = 1'b1;
        bus.underflow = 1'b0;
        bus.rd_data   = '0;
        repeat (3) step();
        rst = 1'b0;
        check("reset_m_data", 32'(bus.m_data), 32'd0);
        check("reset_m_valid", 32'(bus.m_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        step();

        // Streaming: 8 words, consumer always ready.
        bus.m_ready = 1'b1;
        rd_cycles.delete();
        load(8);
        repeat (14) step();
        span = (rd_cycles.size() >= 8) ? rd_cycles[7] - rd_cycles[0] : 0;
        check("stream_rd_count", rd_cycles.size(), 32'd8);
        check("stream_rd_span", span, 32'd7);
        check("stream_drained", exp_q.size(), 32'd0);

        // Backpressure: only two reads may be outstanding.
        bus.m_ready = 1'b0;
        rd_cycles.delete();
        load(4);
        repeat (10) step();
        check("bp_rd_count", rd_cycles.size(), 32'd2);
        check("bp_fifo_left", fifo_q.size(), 32'd2);
        bus.m_ready = 1'b1;
        repeat (8) step();
        check("bp_rd_total", rd_cycles.size(), 32'd4);

        // Empty FIFO: nothing should move.
        repeat (20) step();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_m_valid", 32'(bus.m_valid), 32'd0);

        // Flush with one word buffered and one in flight.
        bus.m_ready = 1'b0;
        load(6);
        step();
        step();
        check("pre_flush_busy", 32'(busy), 32'd1);
        check("pre_flush_m_valid", 32'(bus.m_valid), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_m_valid", 32'(bus.m_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_fifo_left", fifo_q.size(), 32'd4);
        step();
        bus.m_ready = 1'b1;
        repeat (10) step();

        // Reset while a word is presented.
        bus.m_ready = 1'b0;
        load(3);
        step();
        step();
        check("pre_rst_m_valid", 32'(bus.m_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);
        bus.m_ready = 1'b1;
        repeat (6) step();

        // Sticky underflow error.
        bus.underflow = 1'b1;
        step();
        bus.underflow = 1'b0;
        check("err_set", 32'(err_underflow), 32'd1);
        repeat (5) step();
        check("err_sticky", 32'(err_underflow), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("err_cleared", 32'(err_underflow), 32'd0);

`ifdef FIFO_READ_STREAMER_STATS_EN
        // Five handshakes preceded by three stall cycles.
        bus.m_ready = 1'b0;
        load(5);
        repeat (5) step();
        bus.m_ready = 1'b1;
        repeat (10) step();
        check("stats_words", 32'(stat_words), 32'd5);
        check("stats_stalls", 32'(stat_stalls), 32'd3);
`endif

        // Random traffic with occasional flush, underflow and reset.
        for (int unsigned i = 0; i < 1500; i++) begin
            bus.m_ready   = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 49) == 0);
            bus.underflow = ($urandom_range(0, 199) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) load($urandom_range(1, 3));
            step();
        end
        rst           = 1'b0;
        flush         = 1'b0;
        bus.underflow = 1'b0;
        bus.m_ready   = 1'b1;
        repeat (24) step();
        check("drain_fifo", fifo_q.size(), 32'd0);
        check("drain_queue", exp_q.size(), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
